// File: rtl/mem_access_if.sv
// Data-RAM port bundle: request side driven by mem_access, completion side by the RAM.
interface mem_access_if;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        ram_ready;
  logic [31:0] ram_read_data;

  modport master (
    output ram_en,
    output ram_write_en,
    output ram_addr,
    output ram_write_data,
    input  ram_ready,
    input  ram_read_data
  );

  modport slave (
    input  ram_en,
    input  ram_write_en,
    input  ram_addr,
    input  ram_write_data,
    output ram_ready,
    output ram_read_data
  );
endinterface

// File: rtl/mem_access.sv
// MEM-stage data-memory access unit: aligns stores onto byte lanes, runs the RAM
// request/ready handshake, stalls the pipeline while busy and extracts load data.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        mem_read_flag,
  input  logic        mem_write_flag,
  input  logic        mem_sign_ext_flag,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  mem_access_if.master ram,
  output logic        stall_req,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        addr_error
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q;
  logic [1:0]  offset_q;
  logic [3:0]  sel_q;
  logic        sign_q;
  logic        is_load_q;

  logic        sel_ok;
  logic        req;
  logic        misaligned;
  logic        start;
  logic [31:0] shifted;
  logic [31:0] extracted;

  // Request decode and alignment check for the instruction currently in MEM.
  always_comb begin
    sel_ok     = (mem_sel == 4'b0001) | (mem_sel == 4'b0011) | (mem_sel == 4'b1111);
    req        = (mem_read_flag | mem_write_flag) & sel_ok & ~flush;
    misaligned = ((mem_sel == 4'b0011) & mem_addr[0]) |
                 ((mem_sel == 4'b1111) & (|mem_addr[1:0]));
    start      = (state_q == StIdle) & req & ~misaligned;
  end

  // Pipeline-facing status; masked during reset so the reset cycle reads as idle.
  always_comb begin
    stall_req  = ~rst & (start | (state_q == StBusy));
    addr_error = ~rst & (state_q == StIdle) & req & misaligned;
    load_valid = ~rst & (state_q == StDone) & is_load_q & ~flush;
  end

  // Pull the addressed lanes down to bit 0 and extend to 32 bits.
  always_comb begin
    shifted = ram.ram_read_data >> {offset_q, 3'b000};
    case (sel_q)
      4'b0001: extracted = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      4'b0011: extracted = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: extracted = shifted;
    endcase
  end

  // Access FSM with registered RAM port and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= StIdle;
      offset_q           <= 2'b00;
      sel_q              <= 4'b0000;
      sign_q             <= 1'b0;
      is_load_q          <= 1'b0;
      ram.ram_en         <= 1'b0;
      ram.ram_write_en   <= 4'b0000;
      ram.ram_addr       <= 32'h0;
      ram.ram_write_data <= 32'h0;
      load_data          <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            ram.ram_addr       <= {mem_addr[31:2], 2'b00};
            // Store wins when both flags are set.
            ram.ram_write_en   <= mem_write_flag ? (mem_sel << mem_addr[1:0]) : 4'b0000;
            ram.ram_write_data <= mem_write_data << {mem_addr[1:0], 3'b000};
            ram.ram_en         <= 1'b1;
            offset_q           <= mem_addr[1:0];
            sel_q              <= mem_sel;
            sign_q             <= mem_sign_ext_flag;
            is_load_q          <= ~mem_write_flag;
            state_q            <= StBusy;
          end
        end
        StBusy: begin
          // Flush is ignored here: an issued RAM transaction always completes.
          if (ram.ram_ready) begin
            if (is_load_q) begin
              load_data <= extracted;
            end
            ram.ram_en       <= 1'b0;
            ram.ram_write_en <= 4'b0000;
            state_q          <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
